// File: rtl/polar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : polar_pkg                                              |
// | Description : Shared types and helpers for the polar (mag/phase)     |
// |               stream. Phase full scale +/-pi = +/-2^(W-1).           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package polar_pkg;

  // Native width of the CORDIC polar stream
  localparam int POLAR_WIDTH = 32;

  typedef logic signed [POLAR_WIDTH-1:0] phase_t;
  typedef logic        [POLAR_WIDTH-1:0] mag_t;

  // pi and -pi share one code; pi/2 is a quarter turn
  localparam phase_t PHASE_PI   = {1'b1, {(POLAR_WIDTH-1){1'b0}}};
  localparam phase_t PHASE_PI_2 = {2'b01, {(POLAR_WIDTH-2){1'b0}}};

  // Estimator control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } pse_state_t;

  // Phase difference modulo 2^W: wraps naturally through +/-pi
  function automatic phase_t phase_wrap_diff(input phase_t a, input phase_t b);
    return a - b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_slope_estimator_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : phase_diff_gate                                        |
// | Description : Holds the previous phase sample and its low-magnitude  |
// |               flag; outputs the wrapped phase difference, forced to  |
// |               zero when either sample is below THRESHOLD.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module phase_diff_gate
  import polar_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] THRESHOLD = {3'b000, 1'b1, {(WIDTH-4){1'b0}}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] ph,
  input  logic [WIDTH-1:0] mag,
  output logic [WIDTH-1:0] diff,
  output logic             gated
);

  logic [WIDTH-1:0] r_prev_ph;
  logic             r_prev_low;
  logic [WIDTH-1:0] w_raw_diff;
  logic             w_cur_low;

  assign w_cur_low = (mag < THRESHOLD);

  // Use the shared helper at the native stream width, plain modular
  // subtraction otherwise (same arithmetic, any width)
  if (WIDTH == POLAR_WIDTH) begin : g_pkg_diff
    assign w_raw_diff = phase_wrap_diff(ph, r_prev_ph);
  end else begin : g_local_diff
    assign w_raw_diff = ph - r_prev_ph;
  end

  // A difference is trusted only when both endpoints have usable magnitude
  always_comb begin
    gated = r_prev_low | w_cur_low;
    diff  = gated ? '0 : w_raw_diff;
  end

  // Previous sample register, updated on every accepted input sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_ph  <= '0;
      r_prev_low <= 1'b0;
    end else if (load) begin
      r_prev_ph  <= ph;
      r_prev_low <= w_cur_low;
    end
  end

endmodule
`default_nettype wire

// File: rtl/phase_slope_estimator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : phase_slope_estimator                                  |
// | Description : Averages wrapped phase differences over windows of     |
// |               2^LOG2_LEN and emits one phase-increment-per-sample    |
// |               estimate per window (coarse CFO).                      |
// |               Optional macro PHASE_SLOPE_ROUND_EN: round half toward |
// |               +inf instead of floor.                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module phase_slope_estimator
  import polar_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               LOG2_LEN  = 4,
  parameter logic [WIDTH-1:0] THRESHOLD = {3'b000, 1'b1, {(WIDTH-4){1'b0}}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [2*WIDTH-1:0]   s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [LOG2_LEN:0]    m_gated
);

  localparam int ACC_W = WIDTH + LOG2_LEN;
  localparam int CNT_W = LOG2_LEN + 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'((1 << LOG2_LEN) - 1);

  pse_state_t r_state;
  pse_state_t w_state_next;

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_gated;

  logic                    w_accept;
  logic                    w_last;
  logic [WIDTH-1:0]        w_diff;
  logic                    w_gate_flag;
  logic signed [ACC_W-1:0] w_diff_ext;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [WIDTH-1:0]        w_avg;

  // Handshake flags are decodes of the state register, never of m_ready
  assign s_ready  = (r_state != ST_DONE);
  assign m_valid  = (r_state == ST_DONE);
  assign w_accept = s_valid && s_ready;
  assign w_last   = w_accept && (r_state == ST_ACCUM) && (r_cnt == C_LAST_CNT);

  phase_diff_gate #(
    .WIDTH     (WIDTH),
    .THRESHOLD (THRESHOLD)
  ) u_gate (
    .clk   (clk),
    .reset (reset),
    .load  (w_accept),
    .ph    (s_data[WIDTH-1:0]),
    .mag   (s_data[2*WIDTH-1:WIDTH]),
    .diff  (w_diff),
    .gated (w_gate_flag)
  );

  assign w_diff_ext = {{LOG2_LEN{w_diff[WIDTH-1]}}, w_diff};
  assign w_acc_next = r_acc + w_diff_ext;

`ifdef PHASE_SLOPE_ROUND_EN
  localparam logic [ACC_W:0] C_HALF = (ACC_W+1)'(1) << (LOG2_LEN - 1);
  logic [ACC_W:0] w_round_sum;
  logic [LOG2_LEN:0] w_round_unused;
  // Round half toward +inf with one guard bit, then keep WIDTH bits
  assign w_round_sum    = {w_acc_next[ACC_W-1], w_acc_next} + C_HALF;
  assign w_avg          = w_round_sum[ACC_W-1:LOG2_LEN];
  assign w_round_unused = {w_round_sum[ACC_W], w_round_sum[LOG2_LEN-1:0]};
`else
  logic [LOG2_LEN-1:0] w_floor_unused;
  // Arithmetic shift right by LOG2_LEN is a floor divide of the sum
  assign w_avg          = w_acc_next[ACC_W-1:LOG2_LEN];
  assign w_floor_unused = w_acc_next[LOG2_LEN-1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state: first sample primes, 2^LOG2_LEN diffs fill, output waits
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_ACCUM;
      ST_ACCUM: if (w_last)   w_state_next = ST_DONE;
      ST_DONE:  if (m_ready)  w_state_next = ST_ACCUM;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Accumulate the window; on its last difference capture the estimate
  // and clear the running sums so the next window starts from zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_gated <= '0;
      m_data  <= '0;
      m_gated <= '0;
    end else if ((r_state == ST_ACCUM) && w_accept) begin
      if (w_last) begin
        m_data  <= w_avg;
        m_gated <= r_gated + {{(CNT_W-1){1'b0}}, w_gate_flag};
        r_acc   <= '0;
        r_cnt   <= '0;
        r_gated <= '0;
      end else begin
        r_acc   <= w_acc_next;
        r_cnt   <= r_cnt + 1'b1;
        r_gated <= r_gated + {{(CNT_W-1){1'b0}}, w_gate_flag};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_slope_estimator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_phase_slope_estimator                               |
// | Description : Self-checking bench for phase_slope_estimator with a   |
// |               window-level reference model and literal expectations. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_phase_slope_estimator;

  localparam int W  = 16;
  localparam int L2 = 2;
  localparam logic [15:0] TH  = 16'h0100;
  localparam logic [15:0] MAG = 16'h4000;
  localparam logic [15:0] LOW = 16'h0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic [2:0]  m_gated;

  int total = 0;
  int bad   = 0;

  phase_slope_estimator #(.WIDTH(W), .LOG2_LEN(L2), .THRESHOLD(TH)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_gated(m_gated)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (sample list -> window averages) ----
  bit          md_armed = 0;
  bit          md_have_prev;
  logic [15:0] md_prev_ph;
  bit          md_prev_low;
  int          md_cnt, md_sum, md_g;
  bit          md_mv;
  logic [15:0] md_exp_d;
  int          md_exp_g;
  logic [15:0] md_dd;
  logic [15:0] md_ph;
  bit          md_low;
  int          md_q;

  always @(posedge clk) begin
    if (reset) begin
      md_armed = 1; md_have_prev = 0; md_cnt = 0; md_sum = 0; md_g = 0; md_mv = 0;
    end else if (md_mv) begin
      if (m_ready) md_mv = 0;
    end else if (s_valid) begin
      md_ph  = s_data[15:0];
      md_low = (s_data[31:16] < TH);
      if (md_have_prev) begin
        md_dd = md_ph - md_prev_ph;
        if (md_low || md_prev_low) md_g++;
        else md_sum += int'($signed(md_dd));
        md_cnt++;
        if (md_cnt == (1 << L2)) begin
`ifdef PHASE_SLOPE_ROUND_EN
          md_q = (md_sum + (1 << (L2 - 1))) >>> L2;
`else
          md_q = md_sum >>> L2;
`endif
          md_exp_d = md_q[15:0];
          md_exp_g = md_g;
          md_mv = 1; md_cnt = 0; md_sum = 0; md_g = 0;
        end
      end
      md_prev_ph = md_ph; md_prev_low = md_low; md_have_prev = 1;
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (md_armed) begin
      check("cyc_m_valid", {31'd0, m_valid}, {31'd0, md_mv});
      check("cyc_s_ready", {31'd0, s_ready}, {31'd0, !md_mv});
      if (md_mv) begin
        check("cyc_m_data",  {16'd0, m_data}, {16'd0, md_exp_d});
        check("cyc_m_gated", {29'd0, m_gated}, md_exp_g);
      end
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ---------
  task automatic send(input logic [15:0] ph, input logic [15:0] mag);
    int n = 0;
    s_data  = {mag, ph};
    s_valid = 1'b1;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    check("send_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_m_data",  {16'd0, m_data}, 32'd0);
    check("rst_m_gated", {29'd0, m_gated}, 32'd0);
  endtask

  task automatic expect_est(input string name, input logic [15:0] d, input int g);
    check({name, "_valid"}, {31'd0, m_valid}, 32'd1);
    check({name, "_data"},  {16'd0, m_data}, {16'd0, d});
    check({name, "_gated"}, {29'd0, m_gated}, g);
    check({name, "_model"}, {16'd0, md_exp_d}, {16'd0, d});
  endtask

  task automatic ack();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  logic [15:0] round_exp;

  initial begin
    @(negedge clk);
    do_reset();

    // Ramp +0x0100 with backpressure, then boundary-sharing second window
    for (int i = 0; i < 5; i++) send(16'(i * 16'h0100), MAG);
    expect_est("ramp", 16'h0100, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_s_ready", {31'd0, s_ready}, 32'd0);
      check("bp_m_data",  {16'd0, m_data}, 32'h0100);
    end
    ack();
    check("ack_m_valid", {31'd0, m_valid}, 32'd0);
    for (int i = 5; i < 9; i++) send(16'(i * 16'h0100), MAG);
    expect_est("ramp2", 16'h0100, 0);
    ack();

    // Wrap through +pi, with idle gaps mid-window
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(16'h7E00 + 16'(i * 16'h0200), MAG);
      if (i < 4) begin @(negedge clk); @(negedge clk); end
    end
    expect_est("wrap", 16'h0200, 0);
    ack();

    // Negative step -0x0040
    do_reset();
    for (int i = 0; i < 5; i++) send(16'(-(i * 16'h0040)), MAG);
    expect_est("neg", 16'hFFC0, 0);
    ack();

    // Gating: 3rd sample low magnitude kills two differences
    do_reset();
    for (int i = 0; i < 5; i++) send(16'(i * 16'h0100), (i == 2) ? LOW : MAG);
    expect_est("gate", 16'h0080, 2);
    ack();

    // All gated
    do_reset();
    for (int i = 0; i < 5; i++) send(16'(i * 16'h0100), LOW);
    expect_est("allgate", 16'h0000, 4);
    ack();

    // Rounding: diffs 1,1,2,2
    do_reset();
    send(16'd0, MAG); send(16'd1, MAG); send(16'd2, MAG); send(16'd4, MAG); send(16'd6, MAG);
`ifdef PHASE_SLOPE_ROUND_EN
    round_exp = 16'd2;
`else
    round_exp = 16'd1;
`endif
    expect_est("round", round_exp, 0);
    ack();

    // Reset mid-window discards partial window and previous sample
    do_reset();
    for (int i = 0; i < 3; i++) send(16'(i * 16'h0300), MAG);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_m_valid", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 5; i++) send(16'h1000 + 16'(i * 16'h0100), MAG);
    expect_est("fresh", 16'h0100, 0);
    ack();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
